// File: rtl/cn_link_host_pkg.sv
// Shared definitions for the cn_link host: command opcodes, io_link symbol
// encodings, host FSM state type and small byte helpers.
package cn_link_host_pkg;

  // Host command opcodes presented on cmd_op.
  localparam logic [1:0] CN_LINK_OP_INIT        = 2'd0;
  localparam logic [1:0] CN_LINK_OP_START       = 2'd1;
  localparam logic [1:0] CN_LINK_OP_WRITE       = 2'd2;
  localparam logic [1:0] CN_LINK_OP_WRITE_NO_RX = 2'd3;

  // io_link symbols: bit 8 clear = data byte, bit 8 set = command.
  localparam logic [8:0] symbol_idle      = 9'h100;
  localparam logic [8:0] symbol_init      = 9'h101;
  localparam logic [8:0] symbol_start     = 9'h102;
  localparam logic [8:0] symbol_SOF       = 9'h103;
  localparam logic [8:0] symbol_SOF_no_RX = 9'h104;
  localparam logic [8:0] symbol_EOF       = 9'h105;
  localparam logic [8:0] symbol_finished  = 9'h106;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_INIT  = 3'd1,
    ST_SEND_START = 3'd2,
    ST_SOF        = 3'd3,
    ST_DATA       = 3'd4,
    ST_EOF        = 3'd5,
    ST_WAIT_FIN   = 3'd6
  } link_state_e;

  // True when the symbol carries a data byte rather than a command.
  function automatic logic is_data_sym(input logic [8:0] sym);
    is_data_sym = (sym[8] == 1'b0);
  endfunction

  // Byte idx of a 128-bit word, byte 0 in bits [7:0].
  function automatic logic [7:0] get_byte(input logic [127:0] w, input logic [3:0] idx);
    get_byte = w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/cn_link_rx_deser.sv
// Receive deserializer: packs 16 data bytes from the core into one 128-bit
// word (first byte in [7:0]). A SOF from the core or an INIT sent by the host
// drops any partial word so the byte counter realigns with the core.
module cn_link_rx_deser
  import cn_link_host_pkg::*;
(
  input  logic         clk,
  input  logic         reset_l,
  input  logic [8:0]   s_in,
  input  logic         rx_clear,
  output logic         rd_valid,
  output logic [127:0] rd_data
);

  // Only 15 bytes need holding; the 16th is merged straight into rd_data.
  logic [119:0] sr_r;
  logic [3:0]   rx_cnt_r;
  logic         rd_valid_r;
  logic [127:0] rd_data_r;
  logic         resync_s;

  assign resync_s = rx_clear | (s_in == symbol_SOF);

  // Shift in data bytes, emit a word on the 16th byte, resync on SOF/INIT.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sr_r       <= 120'd0;
      rx_cnt_r   <= 4'd0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 128'd0;
    end else begin
      rd_valid_r <= 1'b0;
      if (resync_s) begin
        rx_cnt_r <= 4'd0;
      end else if (is_data_sym(s_in)) begin
        sr_r <= {s_in[7:0], sr_r[119:8]};
        if (rx_cnt_r == 4'd15) begin
          rd_data_r  <= {s_in[7:0], sr_r};
          rd_valid_r <= 1'b1;
          rx_cnt_r   <= 4'd0;
        end else begin
          rx_cnt_r <= rx_cnt_r + 4'd1;
        end
      end else begin
        rx_cnt_r <= rx_cnt_r;
      end
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;

endmodule

// File: rtl/cn_link_host.sv
// Host end of the 9-bit io_link: sends INIT/START commands and SOF/data/EOF
// register-write frames to one cn_core and collects returned data words.
// Optional feature: define CN_LINK_HOST_TIMEOUT_EN to add a WAIT_FIN watchdog
// (TIMEOUT_W bits) that raises sticky sts_timeout and abandons the wait.
module cn_link_host
  import cn_link_host_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [127:0] wr_data,
  input  logic         wr_last,
  output logic [8:0]   s_out,
  input  logic [8:0]   s_in,
  output logic         rd_valid,
  output logic [127:0] rd_data,
  output logic         done,
  output logic         busy,
  output logic         sts_timeout
);

  link_state_e    state_r, state_next_s;
  logic [8:0]     s_out_r, s_out_next_s;
  logic [127:0]   tx_word_r, tx_word_next_s;
  logic           tx_full_r, tx_full_next_s;
  logic           tx_last_r, tx_last_next_s;
  logic [3:0]     byte_idx_r, byte_idx_next_s;
  logic           eof_pend_r, eof_pend_next_s;
  logic           done_r, done_next_s;
  logic           cmd_ready_s, cmd_fire_s, wr_ready_s, wr_fire_s;
  logic           init_fire_s;
  logic [TIMEOUT_W-1:0] wd_cnt_s;
  logic           wd_expired_s;

  assign cmd_ready_s = (state_r == ST_IDLE);
  assign cmd_fire_s  = cmd_valid & cmd_ready_s;
  assign init_fire_s = cmd_fire_s & (cmd_op == CN_LINK_OP_INIT);

  // A new word is taken when nothing is loaded, or while its predecessor's
  // last byte goes out, so consecutive words stream without a gap.
  assign wr_ready_s = ((state_r == ST_SOF) || (state_r == ST_DATA)) && !eof_pend_r &&
                      (!tx_full_r || ((byte_idx_r == 4'd15) && !tx_last_r));
  assign wr_fire_s  = wr_valid & wr_ready_s;

`ifdef CN_LINK_HOST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt_r;
  logic                 sts_timeout_r;

  // Watchdog counts WAIT_FIN cycles from zero; idle elsewhere.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wd_cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (state_r != ST_WAIT_FIN) begin
      wd_cnt_r <= {TIMEOUT_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky timeout flag; only reset or a new INIT clears it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sts_timeout_r <= 1'b0;
    end else if (init_fire_s) begin
      sts_timeout_r <= 1'b0;
    end else if (wd_expired_s && (s_in != symbol_finished)) begin
      sts_timeout_r <= 1'b1;
    end else begin
      sts_timeout_r <= sts_timeout_r;
    end
  end

  assign wd_cnt_s    = wd_cnt_r;
  assign sts_timeout = sts_timeout_r;
`else
  assign wd_cnt_s    = {TIMEOUT_W{1'b0}};
  assign sts_timeout = 1'b0;
`endif

  // Without the watchdog the counter is constant zero and this never fires.
  assign wd_expired_s = (state_r == ST_WAIT_FIN) && (&wd_cnt_s);

  // Next-state and next-symbol logic; s_out is registered from s_out_next_s.
  always_comb begin
    state_next_s    = state_r;
    s_out_next_s    = symbol_idle;
    tx_word_next_s  = tx_word_r;
    tx_full_next_s  = tx_full_r;
    tx_last_next_s  = tx_last_r;
    byte_idx_next_s = byte_idx_r;
    eof_pend_next_s = eof_pend_r;
    done_next_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          tx_full_next_s  = 1'b0;
          eof_pend_next_s = 1'b0;
          byte_idx_next_s = 4'd0;
          case (cmd_op)
            CN_LINK_OP_INIT: begin
              state_next_s = ST_SEND_INIT;
              s_out_next_s = symbol_init;
            end
            CN_LINK_OP_START: begin
              state_next_s = ST_SEND_START;
              s_out_next_s = symbol_start;
            end
            CN_LINK_OP_WRITE: begin
              state_next_s = ST_SOF;
              s_out_next_s = symbol_SOF;
            end
            CN_LINK_OP_WRITE_NO_RX: begin
              state_next_s = ST_SOF;
              s_out_next_s = symbol_SOF_no_RX;
            end
            default: begin
              state_next_s = ST_IDLE;
            end
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND_INIT: begin
        state_next_s = ST_IDLE;
      end
      ST_SEND_START: begin
        state_next_s = ST_WAIT_FIN;
      end
      ST_SOF, ST_DATA: begin
        state_next_s = ST_DATA;
        if (eof_pend_r) begin
          // Last data byte is on the wire now; EOF follows it directly.
          s_out_next_s    = symbol_EOF;
          eof_pend_next_s = 1'b0;
          state_next_s    = ST_EOF;
        end else if (tx_full_r) begin
          s_out_next_s = {1'b0, get_byte(tx_word_r, byte_idx_r)};
          if (byte_idx_r == 4'd15) begin
            byte_idx_next_s = 4'd0;
            if (wr_fire_s) begin
              tx_word_next_s = wr_data;
              tx_last_next_s = wr_last;
            end else begin
              tx_full_next_s  = 1'b0;
              eof_pend_next_s = tx_last_r;
            end
          end else begin
            byte_idx_next_s = byte_idx_r + 4'd1;
          end
        end else if (wr_fire_s) begin
          // Empty: byte 0 of the new word goes out straight away.
          s_out_next_s    = {1'b0, wr_data[7:0]};
          tx_word_next_s  = wr_data;
          tx_full_next_s  = 1'b1;
          tx_last_next_s  = wr_last;
          byte_idx_next_s = 4'd1;
        end else begin
          s_out_next_s = symbol_idle;
        end
      end
      ST_EOF: begin
        state_next_s = ST_IDLE;
      end
      ST_WAIT_FIN: begin
        if (s_in == symbol_finished) begin
          done_next_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else if (wd_expired_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_FIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM, transmit datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r    <= ST_IDLE;
      s_out_r    <= symbol_idle;
      tx_word_r  <= 128'd0;
      tx_full_r  <= 1'b0;
      tx_last_r  <= 1'b0;
      byte_idx_r <= 4'd0;
      eof_pend_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      s_out_r    <= s_out_next_s;
      tx_word_r  <= tx_word_next_s;
      tx_full_r  <= tx_full_next_s;
      tx_last_r  <= tx_last_next_s;
      byte_idx_r <= byte_idx_next_s;
      eof_pend_r <= eof_pend_next_s;
      done_r     <= done_next_s;
    end
  end

  cn_link_rx_deser u_rx (
    .clk      (clk),
    .reset_l  (reset_l),
    .s_in     (s_in),
    .rx_clear (state_r == ST_SEND_INIT),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign cmd_ready = cmd_ready_s;
  assign wr_ready  = wr_ready_s;
  assign s_out     = s_out_r;
  assign done      = done_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cn_link_host.sv
// Directed self-checking bench for cn_link_host.
module tb_cn_link_host;
  import cn_link_host_pkg::*;

`ifdef CN_LINK_HOST_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 24;
`endif

  logic         clk;
  logic         reset_l;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         wr_valid;
  logic         wr_ready;
  logic [127:0] wr_data;
  logic         wr_last;
  logic [8:0]   s_out;
  logic [8:0]   s_in;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         done;
  logic         busy;
  logic         sts_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [127:0] rd_q[$];
  logic [8:0]   sym_q[$];
  logic [8:0]   exp_q[$];

  cn_link_host #(.TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .s_out       (s_out),
    .s_in        (s_in),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .done        (done),
    .busy        (busy),
    .sts_timeout (sts_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record returned words and done pulses away from the active edge.
  always @(negedge clk) begin
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] word_n(input int n);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(n*16 + i);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Runs a whole write frame, capturing s_out while busy. stall = cycles
  // wr_valid is held low while the DUT is empty and waiting for word 1.
  task automatic run_write(input logic [1:0] op, input int nw, input int stall);
    int wi, cyc, rdy_seen, low_cnt;
    logic hs, rdy;
    sym_q.delete();
    wi = 0; rdy_seen = 0; low_cnt = 0; cyc = 0;
    wr_data  = word_n(0);
    wr_last  = (nw == 1);
    wr_valid = 1'b1;
    issue_cmd(op);
    while (cyc < 300) begin
      @(negedge clk);
      if (!busy) break;
      sym_q.push_back(s_out);
      hs  = wr_valid && wr_ready;
      rdy = wr_ready;
      tick();
      if (hs) begin
        wi++;
        if (wi < nw) begin
          wr_data  = word_n(wi);
          wr_last  = (wi == nw - 1);
          wr_valid = (stall == 0);
        end else begin
          wr_valid = 1'b0;
        end
      end else if (!wr_valid && (wi < nw)) begin
        if (rdy) begin
          if (rdy_seen != 0) low_cnt++;
          rdy_seen = 1;
        end
        if (low_cnt >= stall) wr_valid = 1'b1;
      end
      cyc++;
    end
    wr_valid = 1'b0;
    check("frame_terminates", (cyc < 300), 1'b1);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, sym_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < sym_q.size()) ? sym_q[i] : 9'h1FF, exp_q[i]);
  endtask

  task automatic rx_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_in = {1'b0, base + 8'(i)};
      tick();
    end
    s_in = symbol_idle;
  endtask

  initial begin
    int rd_base, done_base, starts, waited;
    reset_l = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; wr_valid = 1'b0;
    wr_data = 128'd0; wr_last = 1'b0; s_in = symbol_idle;
    repeat (3) @(negedge clk);
    check("rst_s_out", s_out, symbol_idle);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sts_timeout", sts_timeout, 1'b0);
    reset_l = 1'b1;
    tick();

    // Two-word write, no stalls: SOF, 00..1F, EOF back to back.
    run_write(CN_LINK_OP_WRITE, 2, 0);
    exp_q.delete();
    exp_q.push_back(symbol_SOF);
    for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, 8'(i)});
    exp_q.push_back(symbol_EOF);
    compare_frame("wr2");

    // Same frame with word 1 withheld for 3 empty cycles.
    tick();
    run_write(CN_LINK_OP_WRITE, 2, 3);
    exp_q.delete();
    exp_q.push_back(symbol_SOF);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'(i)});
    for (int i = 0; i < 3; i++) exp_q.push_back(symbol_idle);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b0, 8'(i)});
    exp_q.push_back(symbol_EOF);
    compare_frame("wr_gap");

    // RX: 16 bytes A0..AF form one word.
    rd_base = rd_q.size();
    rx_bytes(8'hA0, 16);
    tick(); tick();
    check("rx16_count", rd_q.size() - rd_base, 1);
    check("rx16_data", (rd_q.size() > rd_base) ? rd_q[rd_base] : 128'd0,
          128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

    // RX: 7 bytes, SOF, 16 bytes -> only the 16-byte word.
    rd_base = rd_q.size();
    rx_bytes(8'hB0, 7);
    s_in = symbol_SOF; tick(); s_in = symbol_idle;
    rx_bytes(8'hC0, 16);
    tick(); tick();
    check("rx_sof_count", rd_q.size() - rd_base, 1);
    check("rx_sof_data", (rd_q.size() > rd_base) ? rd_q[rd_base] : 128'd0,
          128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

    // RX: 5 bytes, host INIT, 16 bytes -> only the 16-byte word.
    rd_base = rd_q.size();
    rx_bytes(8'hD0, 5);
    issue_cmd(CN_LINK_OP_INIT);
    @(negedge clk);
    check("init_symbol", s_out, symbol_init);
    tick(); tick();
    rx_bytes(8'hE0, 16);
    tick(); tick();
    check("rx_init_count", rd_q.size() - rd_base, 1);
    check("rx_init_data", (rd_q.size() > rd_base) ? rd_q[rd_base] : 128'd0,
          128'hEFEEEDECEBEAE9E8E7E6E5E4E3E2E1E0);

    // START, finished 40 cycles later.
    done_base = done_cnt;
    starts = 0;
    issue_cmd(CN_LINK_OP_START);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_out == symbol_start) starts++;
      tick();
    end
    check("start_busy", busy, 1'b1);
    check("start_count", starts, 1);
    s_in = symbol_finished;
    @(negedge clk);
    check("done_not_early", done, 1'b0);
    tick();
    s_in = symbol_idle;
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_cmd_ready", cmd_ready, 1'b1);
    check("done_busy", busy, 1'b0);
    tick(); tick(); tick();
    check("done_once", done_cnt - done_base, 1);

`ifdef CN_LINK_HOST_TIMEOUT_EN
    // Watchdog: 16 WAIT_FIN cycles then abandon with sticky flag.
    done_base = done_cnt;
    issue_cmd(CN_LINK_OP_START);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        check("to_busy_before", busy, 1'b1);
        check("to_flag_before", sts_timeout, 1'b0);
      end
      if (k == 17) begin
        check("to_busy_after", busy, 1'b0);
        check("to_flag_after", sts_timeout, 1'b1);
      end
      tick();
    end
    check("to_no_done", done_cnt - done_base, 0);
    issue_cmd(CN_LINK_OP_INIT);
    @(negedge clk);
    check("to_init_clears", sts_timeout, 1'b0);
    tick(); tick();
`else
    // No watchdog: WAIT_FIN persists and the flag stays low.
    issue_cmd(CN_LINK_OP_START);
    repeat (30) tick();
    @(negedge clk);
    check("nowd_still_busy", busy, 1'b1);
    check("nowd_flag", sts_timeout, 1'b0);
    s_in = symbol_finished; tick(); s_in = symbol_idle;
    tick();
`endif

    // Reset during byte 5 of a frame, then a fresh INIT + write.
    wr_data = word_n(0); wr_last = 1'b0; wr_valid = 1'b1;
    issue_cmd(CN_LINK_OP_WRITE);
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (s_out == {1'b0, 8'h05}) break;
      waited++;
    end
    check("rst_mid_reached_byte5", (waited < 50), 1'b1);
    #1;
    reset_l = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("rst_mid_s_out", s_out, symbol_idle);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rd_valid", rd_valid, 1'b0);
    tick();
    @(negedge clk);
    check("rst_mid_s_out_edge", s_out, symbol_idle);
    reset_l = 1'b1;
    tick();
    issue_cmd(CN_LINK_OP_INIT);
    tick(); tick();
    run_write(CN_LINK_OP_WRITE_NO_RX, 1, 0);
    exp_q.delete();
    exp_q.push_back(symbol_SOF_no_RX);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'(i)});
    exp_q.push_back(symbol_EOF);
    compare_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
